uart_cmd_sender: RTL and testbench
==================================

UART_CMD_SENDER -- requirements
Module: uart_cmd_sender

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000: consecutive stable cycles needed before a button change is accepted.
REQ-002 Parameter REPEAT_CYCLES, default 5000000: resend interval in IDLE; used only when CMD_REPEAT_EN is defined.
REQ-003 clock  input  1  sole clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_fd, in_back, in_left, in_right  input  1 each  direction buttons; active-low (0 = pressed); asynchronous to clock.
REQ-006 stop  input  1  obstacle flag from processor; 1 = forward motion forbidden.
REQ-007 tx_done  input  1  one-cycle pulse from UART transmitter at end of a byte.
REQ-008 tx_en  output  1  transmit request to UART transmitter.
REQ-009 tx_data  output  8  byte to transmit.
REQ-010 cmd_code  output  8  current encoded command, derived from debounced buttons.
REQ-011 busy  output  1  high whenever FSM is not in IDLE.

Function
REQ-012 Each button SHALL pass a 2-flop synchronizer, then a debouncer; the debounced level updates only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle clears the counter.
REQ-013 cmd_code SHALL be combinational from debounced levels: fd only 0x01; fd+right 0x02; right only 0x03; back+right 0x04; back only 0x05; back+left 0x06; left only 0x07; fd+left 0x08; any other combination 0x00.
REQ-014 When stop=1, codes 0x01, 0x02 and 0x08 SHALL be replaced by 0x00.
REQ-015 FSM states: IDLE, SEND, GAP.
REQ-016 IDLE: if cmd_code != last_sent, latch tx_data and last_sent from cmd_code and go to SEND on the next edge.
REQ-017 SEND: tx_en=1 and tx_data held constant; on tx_done=1, go to GAP.
REQ-018 GAP: tx_en=0 for exactly one cycle, then IDLE.
REQ-019 Latency: cmd_code change visible in cycle N gives tx_en=1 in cycle N+1.
REQ-020 tx_done SHALL be ignored in IDLE and GAP.
REQ-021 cmd_code changes during SEND/GAP SHALL NOT alter tx_data; only the latest code at return to IDLE is sent, so intermediate codes are dropped.
REQ-022 Release (transition to 0x00) SHALL be transmitted like any other code.

Reset
REQ-023 On reset: state IDLE, tx_en=0, tx_data=0x00, last_sent=0x00, busy=0, debounced levels=1 (released), synchronizers=1, all counters 0.
REQ-024 Reset asserted mid-SEND SHALL abort the byte; tx_en falls in the cycle after the reset edge.

Configuration
REQ-025 With CMD_REPEAT_EN defined: in IDLE with cmd_code != 0x00 and equal to last_sent, a counter SHALL count to REPEAT_CYCLES and then resend the same code. The counter clears on every entry to SEND and whenever cmd_code is 0x00.
REQ-026 Without CMD_REPEAT_EN: bytes are sent only on code change; no repeat counter is synthesized.

Structure
REQ-027 Package uart_cmd_pkg SHALL hold the FSM state enum, the CMD_* code constants (0x00-0x08) and the parameter defaults.
REQ-028 Sub-module button_debounce (synchronizer plus counter, parameterized by DEBOUNCE_CYCLES) SHALL be instantiated four times.

Verification (bench uses DEBOUNCE_CYCLES=4, REPEAT_CYCLES=20)
REQ-029 Press in_fd=0 held 10 cycles -> cmd_code=0x01 once debounced; tx_en rises next cycle with tx_data=0x01; tx_done pulse -> one GAP cycle, then IDLE.
REQ-030 in_fd=0 glitch of 2 cycles -> cmd_code stays 0x00; tx_en never asserted.
REQ-031 Forward held, then stop=1 -> cmd_code=0x00 and 0x00 is transmitted; stop=0 -> 0x01 is transmitted again.
REQ-032 During SEND of 0x05, buttons change to 0x06 then 0x07 -> tx_data stays 0x05 until tx_done; the next byte is 0x07 only.
REQ-033 Reset asserted while tx_en=1 -> tx_en=0 and tx_data=0x00 the next cycle; with all buttons released, nothing is sent afterwards.
REQ-034 With CMD_REPEAT_EN, 0x03 held and tx_done returned promptly -> 0x03 resent every 20 IDLE cycles; without the macro, exactly one send occurs.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared types, command codes and parameter defaults for the UART command sender.
// Command encoding is a pure function of debounced buttons plus the obstacle flag.
package uart_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    localparam logic [7:0] CMD_NONE       = 8'h00;
    localparam logic [7:0] CMD_FD         = 8'h01;
    localparam logic [7:0] CMD_FD_RIGHT   = 8'h02;
    localparam logic [7:0] CMD_RIGHT      = 8'h03;
    localparam logic [7:0] CMD_BACK_RIGHT = 8'h04;
    localparam logic [7:0] CMD_BACK       = 8'h05;
    localparam logic [7:0] CMD_BACK_LEFT  = 8'h06;
    localparam logic [7:0] CMD_LEFT       = 8'h07;
    localparam logic [7:0] CMD_FD_LEFT    = 8'h08;

    localparam int DEBOUNCE_CYCLES_DEF = 50000;
    localparam int REPEAT_CYCLES_DEF   = 5000000;

    // Inputs are active-high "pressed" flags; stop vetoes every code with a forward component.
    function automatic logic [7:0] encode_cmd(input logic fd, input logic back,
                                              input logic left, input logic right,
                                              input logic stop);
        logic [7:0] code;
        case ({fd, back, left, right})
            4'b1000: code = CMD_FD;
            4'b1001: code = CMD_FD_RIGHT;
            4'b0001: code = CMD_RIGHT;
            4'b0101: code = CMD_BACK_RIGHT;
            4'b0100: code = CMD_BACK;
            4'b0110: code = CMD_BACK_LEFT;
            4'b0010: code = CMD_LEFT;
            4'b1010: code = CMD_FD_LEFT;
            default: code = CMD_NONE;
        endcase
        if (stop && (code == CMD_FD || code == CMD_FD_RIGHT || code == CMD_FD_LEFT)) begin
            code = CMD_NONE;
        end
        return code;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer followed by a stability counter; level_o follows the
// synchronized input only after it has disagreed for DEBOUNCE_CYCLES cycles in a row.
module button_debounce
    import uart_cmd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_i,
    output logic level_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/uart_cmd_sender.sv
// Debounces four direction buttons, encodes a command byte and hands each new code to a UART.
// Define CMD_REPEAT_EN to periodically resend a held non-zero code every REPEAT_CYCLES idle cycles.
module uart_cmd_sender
    import uart_cmd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_fd,
    input  logic       in_back,
    input  logic       in_left,
    input  logic       in_right,
    input  logic       stop,
    input  logic       tx_done,
    output logic       tx_en,
    output logic [7:0] tx_data,
    output logic [7:0] cmd_code,
    output logic       busy
);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
        $error("uart_cmd_sender: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 1");
    end

    logic deb_fd, deb_back, deb_left, deb_right;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_fd (
        .clock(clock), .reset(reset), .btn_i(in_fd), .level_o(deb_fd));
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_back (
        .clock(clock), .reset(reset), .btn_i(in_back), .level_o(deb_back));
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
        .clock(clock), .reset(reset), .btn_i(in_left), .level_o(deb_left));
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
        .clock(clock), .reset(reset), .btn_i(in_right), .level_o(deb_right));

    assign cmd_code = encode_cmd(~deb_fd, ~deb_back, ~deb_left, ~deb_right, stop);

    state_e     state_q, state_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic [7:0] last_q, last_d;
    logic       rpt_hit;
    logic       start;

`ifdef CMD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    logic [RW-1:0] rpt_q, rpt_d;

    assign rpt_hit = (cmd_code != CMD_NONE) && (cmd_code == last_q) &&
                     (rpt_q == RW'(REPEAT_CYCLES - 1));
    // Only counts idle cycles spent holding the already-sent code.
    assign rpt_d   = (state_q != ST_IDLE || cmd_code == CMD_NONE || start) ? '0 : rpt_q + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            rpt_q <= '0;
        end else begin
            rpt_q <= rpt_d;
        end
    end
`else
    assign rpt_hit = 1'b0;
`endif

    assign start = (state_q == ST_IDLE) && ((cmd_code != last_q) || rpt_hit);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            tx_data_q <= 8'h00;
            last_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            last_q    <= last_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        last_d    = last_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    tx_data_d = cmd_code;
                    last_d    = cmd_code;
                    state_d   = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tx_done) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign tx_en   = (state_q == ST_SEND);
    assign tx_data = tx_data_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_sender.sv
// Directed bench for uart_cmd_sender with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=20.
module tb_uart_cmd_sender;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_fd, in_back, in_left, in_right;
    logic       stop, tx_done;
    logic       tx_en, busy;
    logic [7:0] tx_data, cmd_code;

    int n_vec     = 0;
    int n_miscmp  = 0;

    always #5 clock = ~clock;

    uart_cmd_sender #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(20)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_fd    (in_fd),
        .in_back  (in_back),
        .in_left  (in_left),
        .in_right (in_right),
        .stop     (stop),
        .tx_done  (tx_done),
        .tx_en    (tx_en),
        .tx_data  (tx_data),
        .cmd_code (cmd_code),
        .busy     (busy)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_tx(input string tag, input int max_cyc);
        for (int i = 0; i < max_cyc && tx_en !== 1'b1; i++) @(negedge clock);
        check_val(tag, 32'(tx_en), 1);
    endtask

    // Entered at a negedge in SEND; returns at the first negedge back in IDLE.
    task automatic send_done(input string tag);
        tx_done = 1'b1;
        @(negedge clock);
        tx_done = 1'b0;
        check_val({tag, "_gap_txen"}, 32'(tx_en), 0);
        check_val({tag, "_gap_busy"}, 32'(busy), 1);
        @(negedge clock);
        check_val({tag, "_idle_busy"}, 32'(busy), 0);
    endtask

    initial begin
        logic seen;
        reset = 1'b1; stop = 1'b0; tx_done = 1'b0;
        in_fd = 1'b1; in_back = 1'b1; in_left = 1'b1; in_right = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_val("rst_txen",  32'(tx_en), 0);
        check_val("rst_data",  32'(tx_data), 0);
        check_val("rst_busy",  32'(busy), 0);
        check_val("rst_code",  32'(cmd_code), 0);

        // 2-cycle glitch must be filtered
        in_fd = 1'b0;
        repeat (2) @(negedge clock);
        in_fd = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (tx_en || cmd_code != 8'h00) seen = 1'b1;
        end
        check_val("glitch_ignored", 32'(seen), 0);

        // Forward press: 2 sync edges + 4 stable edges, then tx_en one cycle later
        in_fd = 1'b0;
        repeat (5) @(negedge clock);
        check_val("fd_not_yet", 32'(cmd_code), 8'h00);
        @(negedge clock);
        check_val("fd_code", 32'(cmd_code), 8'h01);
        check_val("fd_txen_lat0", 32'(tx_en), 0);
        @(negedge clock);
        check_val("fd_txen_lat1", 32'(tx_en), 1);
        check_val("fd_data", 32'(tx_data), 8'h01);
        check_val("fd_busy", 32'(busy), 1);
        repeat (3) @(negedge clock);
        check_val("fd_hold_txen", 32'(tx_en), 1);
        send_done("fd");
        tx_done = 1'b1;
        @(negedge clock);
        tx_done = 1'b0;
        check_val("idle_done_ignored", 32'(busy), 0);

        // Obstacle vetoes forward, clearing it resends forward
        stop = 1'b1;
        #1;
        check_val("stop_code", 32'(cmd_code), 8'h00);
        @(negedge clock);
        check_val("stop_txen", 32'(tx_en), 1);
        check_val("stop_data", 32'(tx_data), 8'h00);
        send_done("stop");
        stop = 1'b0;
        #1;
        check_val("unstop_code", 32'(cmd_code), 8'h01);
        @(negedge clock);
        check_val("unstop_txen", 32'(tx_en), 1);
        check_val("unstop_data", 32'(tx_data), 8'h01);
        send_done("unstop");

        // Back, then changes during SEND are held off; only the final code follows
        in_fd = 1'b1; in_back = 1'b0;
        wait_tx("back_txen", 20);
        check_val("back_data", 32'(tx_data), 8'h05);
        in_left = 1'b0;
        repeat (8) @(negedge clock);
        check_val("bl_code", 32'(cmd_code), 8'h06);
        check_val("bl_data_held", 32'(tx_data), 8'h05);
        in_back = 1'b1;
        repeat (8) @(negedge clock);
        check_val("left_code", 32'(cmd_code), 8'h07);
        check_val("left_data_held", 32'(tx_data), 8'h05);
        check_val("left_txen_held", 32'(tx_en), 1);
        send_done("back");
        @(negedge clock);
        check_val("left_txen", 32'(tx_en), 1);
        check_val("left_data", 32'(tx_data), 8'h07);
        send_done("left");

        // Release is sent as 0x00
        in_left = 1'b1;
        wait_tx("rel_txen", 20);
        check_val("rel_data", 32'(tx_data), 8'h00);
        send_done("rel");

        // Reset mid-SEND aborts; released buttons produce nothing afterwards
        in_right = 1'b0;
        wait_tx("rst_pre_txen", 20);
        check_val("rst_pre_data", 32'(tx_data), 8'h03);
        reset = 1'b1; in_right = 1'b1;
        @(negedge clock);
        check_val("rst_mid_txen", 32'(tx_en), 0);
        check_val("rst_mid_data", 32'(tx_data), 8'h00);
        check_val("rst_mid_code", 32'(cmd_code), 8'h00);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            if (tx_en) seen = 1'b1;
        end
        check_val("rst_quiet", 32'(seen), 0);

        // Held right: periodic resend only with the repeat feature
        in_right = 1'b0;
        wait_tx("rpt_first_txen", 20);
        check_val("rpt_first_data", 32'(tx_data), 8'h03);
        send_done("rpt_first");
`ifdef CMD_REPEAT_EN
        for (int r = 0; r < 2; r++) begin
            seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (tx_en) seen = 1'b1;
                @(negedge clock);
            end
            check_val("rpt_no_early", 32'(seen), 0);
            check_val("rpt_resend_txen", 32'(tx_en), 1);
            check_val("rpt_resend_data", 32'(tx_data), 8'h03);
            send_done("rpt_resend");
        end
`else
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (tx_en) seen = 1'b1;
        end
        check_val("norpt_single", 32'(seen), 0);
`endif
        in_right = 1'b1;
        repeat (4) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
